// File: rtl/regfile_mp_sb.sv
// Multi-port integer register file with two write ports, combinational read
// ports with optional write bypass, and a per-register busy scoreboard.
module regfile_mp_sb #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned NUM_RD   = 2,
  parameter int unsigned BYPASS   = 1,
  parameter int unsigned ZERO_REG = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       we0,
  input  logic [ADDR_W-1:0]          waddr0,
  input  logic [DATA_W-1:0]          wdata0,
  input  logic                       we1,
  input  logic [ADDR_W-1:0]          waddr1,
  input  logic [DATA_W-1:0]          wdata1,
  input  logic [NUM_RD*ADDR_W-1:0]   raddr,
  output logic [NUM_RD*DATA_W-1:0]   rdata,
  output logic [NUM_RD-1:0]          rbusy,
  input  logic                       issue_valid,
  input  logic [ADDR_W-1:0]          issue_addr,
  input  logic                       flush,
  output logic                       busy_any
);

  localparam int unsigned DEPTH = 32'(1) << ADDR_W;

  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [DATA_W-1:0] regs_d [DEPTH];
  logic [DEPTH-1:0]  busy_q, busy_d;
  logic              busy_any_q, busy_any_d;
  logic              wr0_ok, wr1_ok, iss_ok;

  // Writes and issues aimed at a hardwired-zero register are dropped.
  always_comb begin
    wr0_ok = we0 && !((ZERO_REG != 0) && (waddr0 == '0));
    wr1_ok = we1 && !((ZERO_REG != 0) && (waddr1 == '0));
    iss_ok = issue_valid && !((ZERO_REG != 0) && (issue_addr == '0));
  end

  // Next-state: W1 applied last so it wins a same-address collision.
  always_comb begin
    regs_d = regs_q;
    busy_d = busy_q;
    if (wr0_ok) regs_d[waddr0] = wdata0;
    if (wr1_ok) regs_d[waddr1] = wdata1;
    if (flush) begin
      busy_d = '0;
    end else begin
      if (wr0_ok) busy_d[waddr0] = 1'b0;
      if (wr1_ok) busy_d[waddr1] = 1'b0;
      if (iss_ok) busy_d[issue_addr] = 1'b1;
    end
    busy_any_d = |busy_d;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(DEPTH); i++) regs_q[i] <= '0;
      busy_q     <= '0;
      busy_any_q <= 1'b0;
    end else begin
      regs_q     <= regs_d;
      busy_q     <= busy_d;
      busy_any_q <= busy_any_d;
    end
  end

  assign busy_any = busy_any_q;

  // Read ports: bypass, zero-register and reset masking applied in that order.
  always_comb begin
    logic [ADDR_W-1:0] ra;
    logic [DATA_W-1:0] rd;
    logic              rb;
    rdata = '0;
    rbusy = '0;
    ra    = '0;
    rd    = '0;
    rb    = 1'b0;
    for (int k = 0; k < int'(NUM_RD); k++) begin
      ra = raddr[k*ADDR_W +: ADDR_W];
      rd = regs_q[ra];
      rb = busy_q[ra];
      if (BYPASS != 0) begin
        if (we1 && (waddr1 == ra)) begin
          rd = wdata1;
          rb = 1'b0;
        end else if (we0 && (waddr0 == ra)) begin
          rd = wdata0;
          rb = 1'b0;
        end
      end
      if ((ZERO_REG != 0) && (ra == '0)) begin
        rd = '0;
        rb = 1'b0;
      end
      if (!reset) begin
        rd = '0;
        rb = 1'b0;
      end
      rdata[k*DATA_W +: DATA_W] = rd;
      rbusy[k]                  = rb;
    end
  end

endmodule

// File: tb/tb_regfile_mp_sb.sv
// Directed bench for regfile_mp_sb: a bypassing and a non-bypassing instance
// share all inputs so both read behaviours are checked from one stimulus stream.
module tb_regfile_mp_sb;

  logic        clk = 1'b0;
  logic        reset;
  logic        we0, we1, issue_valid, flush;
  logic [4:0]  waddr0, waddr1, issue_addr;
  logic [31:0] wdata0, wdata1;
  logic [9:0]  raddr;
  logic [63:0] rdata, nrdata;
  logic [1:0]  rbusy, nrbusy;
  logic        busy_any, nbusy_any;
  logic [31:0] rd0, rd1, nrd0, nrd1;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  assign rd0  = rdata[31:0];
  assign rd1  = rdata[63:32];
  assign nrd0 = nrdata[31:0];
  assign nrd1 = nrdata[63:32];

  regfile_mp_sb #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .BYPASS(1), .ZERO_REG(1)) dut (
    .clk(clk), .reset(reset),
    .we0(we0), .waddr0(waddr0), .wdata0(wdata0),
    .we1(we1), .waddr1(waddr1), .wdata1(wdata1),
    .raddr(raddr), .rdata(rdata), .rbusy(rbusy),
    .issue_valid(issue_valid), .issue_addr(issue_addr), .flush(flush),
    .busy_any(busy_any)
  );

  regfile_mp_sb #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .BYPASS(0), .ZERO_REG(1)) dut_nb (
    .clk(clk), .reset(reset),
    .we0(we0), .waddr0(waddr0), .wdata0(wdata0),
    .we1(we1), .waddr1(waddr1), .wdata1(wdata1),
    .raddr(raddr), .rdata(nrdata), .rbusy(nrbusy),
    .issue_valid(issue_valid), .issue_addr(issue_addr), .flush(flush),
    .busy_any(nbusy_any)
  );

  task automatic idle();
    we0 = 1'b0; waddr0 = '0; wdata0 = '0;
    we1 = 1'b0; waddr1 = '0; wdata1 = '0;
    issue_valid = 1'b0; issue_addr = '0; flush = 1'b0;
  endtask

  // Advance past the next rising edge; inputs are then driven mid-cycle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    idle();
    raddr = {5'd31, 5'd5};
    tick();
    we1 = 1'b1; waddr1 = 5'd5; wdata1 = 32'hFFFF_0000;
    #1;
    nvec++; if (rd0 !== 32'h0) begin nerr++; $display("FAIL reset_bypass_mask rd0 got %h exp 0", rd0); end
    tick();
    reset = 1'b1;
    idle();
    #1;
    nvec++; if (rd0 !== 32'h0 || rd1 !== 32'h0) begin nerr++; $display("FAIL reset_rdata got %h/%h exp 0/0", rd0, rd1); end
    nvec++; if (rbusy !== 2'b00) begin nerr++; $display("FAIL reset_rbusy got %b exp 00", rbusy); end
    nvec++; if (busy_any !== 1'b0 || nbusy_any !== 1'b0) begin nerr++; $display("FAIL reset_busy_any got %b/%b exp 0/0", busy_any, nbusy_any); end
  endtask

  task automatic test_write_read();
    we0 = 1'b1; waddr0 = 5'd7; wdata0 = 32'hDEAD_BEEF;
    tick();
    idle();
    raddr = {5'd7, 5'd7};
    #1;
    nvec++; if (rd0 !== 32'hDEAD_BEEF || nrd1 !== 32'hDEAD_BEEF) begin nerr++; $display("FAIL write_read_r7 got %h/%h exp deadbeef", rd0, nrd1); end
    we0 = 1'b1; waddr0 = 5'd0; wdata0 = 32'h0000_1234;
    raddr = {5'd7, 5'd0};
    #1;
    nvec++; if (rd0 !== 32'h0) begin nerr++; $display("FAIL zero_reg_bypass got %h exp 0", rd0); end
    tick();
    idle();
    #1;
    nvec++; if (rd0 !== 32'h0 || nrd0 !== 32'h0) begin nerr++; $display("FAIL zero_reg_stored got %h/%h exp 0/0", rd0, nrd0); end
  endtask

  task automatic test_collision_bypass();
    we0 = 1'b1; waddr0 = 5'd3; wdata0 = 32'h11;
    we1 = 1'b1; waddr1 = 5'd3; wdata1 = 32'h22;
    raddr = {5'd3, 5'd7};
    #1;
    nvec++; if (rd1 !== 32'h22) begin nerr++; $display("FAIL collision_bypass got %h exp 22", rd1); end
    nvec++; if (nrd1 !== 32'h0) begin nerr++; $display("FAIL collision_nobypass got %h exp 0", nrd1); end
    nvec++; if (rd0 !== 32'hDEAD_BEEF) begin nerr++; $display("FAIL collision_other_port got %h exp deadbeef", rd0); end
    tick();
    idle();
    #1;
    nvec++; if (rd1 !== 32'h22 || nrd1 !== 32'h22) begin nerr++; $display("FAIL collision_stored got %h/%h exp 22/22", rd1, nrd1); end
    we0 = 1'b1; waddr0 = 5'd12; wdata0 = 32'h77;
    raddr = {5'd3, 5'd12};
    #1;
    nvec++; if (rd0 !== 32'h77 || nrd0 !== 32'h0) begin nerr++; $display("FAIL w0_bypass got %h/%h exp 77/0", rd0, nrd0); end
    tick();
    idle();
  endtask

  task automatic test_scoreboard();
    issue_valid = 1'b1; issue_addr = 5'd9;
    tick();
    idle();
    raddr = {5'd3, 5'd9};
    #1;
    nvec++; if (rbusy !== 2'b01 || nrbusy !== 2'b01) begin nerr++; $display("FAIL issue_rbusy got %b/%b exp 01/01", rbusy, nrbusy); end
    nvec++; if (busy_any !== 1'b1) begin nerr++; $display("FAIL issue_busy_any got %b exp 1", busy_any); end
    we1 = 1'b1; waddr1 = 5'd9; wdata1 = 32'hAA;
    #1;
    nvec++; if (rbusy[0] !== 1'b0 || rd0 !== 32'hAA) begin nerr++; $display("FAIL wb_bypass got busy %b data %h exp 0/aa", rbusy[0], rd0); end
    nvec++; if (nrbusy[0] !== 1'b1 || nrd0 !== 32'h0) begin nerr++; $display("FAIL wb_nobypass got busy %b data %h exp 1/0", nrbusy[0], nrd0); end
    nvec++; if (busy_any !== 1'b1) begin nerr++; $display("FAIL wb_busy_any_same_cycle got %b exp 1", busy_any); end
    tick();
    idle();
    #1;
    nvec++; if (nrbusy[0] !== 1'b0 || busy_any !== 1'b0) begin nerr++; $display("FAIL wb_cleared got %b/%b exp 0/0", nrbusy[0], busy_any); end
  endtask

  task automatic test_set_wins();
    issue_valid = 1'b1; issue_addr = 5'd4;
    we0 = 1'b1; waddr0 = 5'd4; wdata0 = 32'h55;
    tick();
    idle();
    raddr = {5'd0, 5'd4};
    #1;
    nvec++; if (rbusy[0] !== 1'b1 || rd0 !== 32'h55) begin nerr++; $display("FAIL set_wins got busy %b data %h exp 1/55", rbusy[0], rd0); end
    we1 = 1'b1; waddr1 = 5'd4; wdata1 = 32'h55;
    issue_valid = 1'b1; issue_addr = 5'd0;
    tick();
    idle();
    #1;
    nvec++; if (rbusy !== 2'b00 || busy_any !== 1'b0) begin nerr++; $display("FAIL issue_r0 got %b/%b exp 00/0", rbusy, busy_any); end
  endtask

  task automatic test_flush();
    for (int i = 1; i <= 3; i++) begin
      issue_valid = 1'b1; issue_addr = 5'(i);
      tick();
    end
    idle();
    raddr = {5'd2, 5'd1};
    #1;
    nvec++; if (rbusy !== 2'b11 || busy_any !== 1'b1) begin nerr++; $display("FAIL pre_flush got %b/%b exp 11/1", rbusy, busy_any); end
    flush = 1'b1; issue_valid = 1'b1; issue_addr = 5'd6;
    tick();
    idle();
    raddr = {5'd6, 5'd3};
    #1;
    nvec++; if (rbusy !== 2'b00 || busy_any !== 1'b0) begin nerr++; $display("FAIL flush got %b/%b exp 00/0", rbusy, busy_any); end
  endtask

  task automatic test_reset_mid();
    we1 = 1'b1; waddr1 = 5'd10; wdata1 = 32'h1111;
    issue_valid = 1'b1; issue_addr = 5'd11;
    tick();
    idle();
    we1 = 1'b1; waddr1 = 5'd10; wdata1 = 32'hCAFE;
    raddr = {5'd11, 5'd10};
    #1;
    nvec++; if (rd0 !== 32'hCAFE || nrd0 !== 32'h1111) begin nerr++; $display("FAIL mid_pre got %h/%h exp cafe/1111", rd0, nrd0); end
    nvec++; if (rbusy[1] !== 1'b1 || busy_any !== 1'b1) begin nerr++; $display("FAIL mid_pre_busy got %b/%b exp 1/1", rbusy[1], busy_any); end
    #1;
    reset = 1'b0;
    #1;
    nvec++; if (rd0 !== 32'h0 || nrd0 !== 32'h0) begin nerr++; $display("FAIL mid_reset_data got %h/%h exp 0/0", rd0, nrd0); end
    nvec++; if (rbusy !== 2'b00 || busy_any !== 1'b0) begin nerr++; $display("FAIL mid_reset_busy got %b/%b exp 00/0", rbusy, busy_any); end
    tick();
    reset = 1'b1;
    idle();
    #1;
    nvec++; if (rd0 !== 32'h0 || nrd0 !== 32'h0) begin nerr++; $display("FAIL post_reset_r10 got %h/%h exp 0/0", rd0, nrd0); end
    nvec++; if (nrbusy[1] !== 1'b0 || nbusy_any !== 1'b0) begin nerr++; $display("FAIL post_reset_busy got %b/%b exp 0/0", nrbusy[1], nbusy_any); end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_collision_bypass();
    test_scoreboard();
    test_set_wins();
    test_flush();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/regfile_mp_sb.md
Name: regfile_mp_sb

Overview:
- Parametrised multi-port integer register file for the core's decode/writeback stages.
- Two write ports: W0 for ALU writeback, W1 for load/mul writeback.
- NUM_RD combinational read ports, optional same-cycle write-to-read bypass, optional hardwired-zero register 0.
- Per-register busy scoreboard: decode sets a bit on issue, writeback clears it. Decode uses it to stall on RAW hazards.

Parameters:
DATA_W, 32, register width in bits
ADDR_W, 5, address width; depth = 2**ADDR_W registers
NUM_RD, 2, number of read ports (legal 1..4)
BYPASS, 1, 1 = read data reflects same-cycle write data; 0 = read returns stored value only
ZERO_REG, 1, 1 = register 0 reads 0, ignores writes, is never busy

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
we0  in  1  write enable, port 0
waddr0  in  ADDR_W  write address, port 0
wdata0  in  DATA_W  write data, port 0
we1  in  1  write enable, port 1 (priority port)
waddr1  in  ADDR_W  write address, port 1
wdata1  in  DATA_W  write data, port 1
raddr  in  NUM_RD*ADDR_W  read addresses; port k uses bits [k*ADDR_W +: ADDR_W]
rdata  out  NUM_RD*DATA_W  read data; port k uses bits [k*DATA_W +: DATA_W]
rbusy  out  NUM_RD  busy flag for each read address
issue_valid  in  1  mark issue_addr busy at next edge
issue_addr  in  ADDR_W  destination register being issued
flush  in  1  synchronous clear of all busy bits
busy_any  out  1  OR of all busy bits (registered state, no bypass)

Behaviour:
- Reset (reset=0, asynchronous):
  - all registers and busy bits cleared to 0 immediately.
  - rdata forced to 0 and rbusy forced to 0 while reset is low, regardless of bypass inputs.
  - busy_any=0.
- Writes (posedge clk):
  - we0 writes wdata0 to waddr0; we1 writes wdata1 to waddr1.
  - Both enabled to the same address: W1 wins, W0 is dropped.
  - ZERO_REG=1: any write to address 0 is ignored.
- Reads, combinational, zero latency:
  - BYPASS=0: rdata[k] = stored value at raddr[k].
  - BYPASS=1: if we1 is active and waddr1 matches raddr[k], rdata[k] = wdata1. Otherwise if we0 is active and waddr0 matches, rdata[k] = wdata0. Otherwise the stored value. W1 therefore has priority over W0.
  - ZERO_REG=1 and raddr[k]=0: rdata[k]=0 and rbusy[k]=0 always, including during bypass.
- Scoreboard, updated at posedge clk, in this priority order:
  1. flush=1: all busy bits go to 0. Any issue_valid in that cycle is ignored.
  2. Otherwise, an enabled write to address A clears busy[A] (either port).
  3. issue_valid sets busy[issue_addr]. If it targets the same address as a write in the same cycle, set wins: a new producer supersedes the old one. ZERO_REG=1 and issue_addr=0: no effect.
- rbusy[k]:
  - equals busy[raddr[k]].
  - BYPASS=1: forced to 0 when a same-cycle write to raddr[k] is active, since the data is valid on rdata.
  - BYPASS=0: rbusy[k] reflects stored busy only.
- busy_any is the OR of the stored busy vector only; same-cycle writes do not affect it.
- Wrap-around: none; every address in 0..2**ADDR_W-1 is valid.
- Reset asserted mid-operation: pending writes and issues in that cycle are discarded.
- Reset deassertion is synchronised externally; the block needs no warm-up cycle.
- Implementation: flop array, not inferred RAM (NUM_RD async read ports). No X propagation from unwritten entries: all are 0 after reset.

Test Plan:
- Reset then read: assert reset=0 for 2 cycles, release, raddr={5,31} -> rdata=0 on both ports, rbusy=0, busy_any=0.
- Write/read and zero register: W0 writes 0xDEADBEEF to r7, next cycle raddr0=7 -> 0xDEADBEEF. W0 writes 0x1234 to r0 -> read of r0 returns 0.
- Dual-write collision plus bypass (BYPASS=1):
  - Same cycle: we0 (r3, 0x11) and we1 (r3, 0x22), raddr1=3 -> rdata1=0x22 combinationally that cycle.
  - Stored value afterwards is 0x22.
  - With BYPASS=0, the same-cycle read returns the old value 0.
- Scoreboard lifecycle:
  - issue r9 -> next cycle rbusy=1 on raddr=9 and busy_any=1.
  - W1 writes r9=0xAA -> rbusy=0 that cycle (bypass), busy bit clear the next cycle.
- Set-wins collision:
  - Same cycle: issue r4 and W0 writes r4=0x55 -> next cycle busy[4]=1, data=0x55.
  - issue r0 -> busy stays 0.
- Flush and reset mid-operation:
  - Busy on r1, r2, r3: flush plus issue r6 in the same cycle -> all busy=0, r6 not busy.
  - Async reset asserted mid-cycle during we1 to r10 -> r10=0 immediately and after release.
